rf_write_arbiter: RTL

Write-port arbiter and load scoreboard for the 32×32 register file. Shares the single register-file write port between the ALU writeback path and late-returning memory loads. Buffers loads in a small FIFO and tracks registers with outstanding loads so decode can stall on hazards. Sits between execute/memory stages and the register file's write_enable_flag / a3 / write_data_input inputs.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_ld_fifo.sv | 68 ++++++
 rtl/rf_write_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  // One pending register-file write: destination plus data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rf_wr_t;

endpackage

// File: rtl/rf_ld_fifo.sv
// Small FIFO holding returned loads until the register-file write port is free.
// Latency: an entry pushed at edge N is visible at head (empty=0) after edge N.
// Backpressure: full=1 means no room; push is ignored while full, pop ignored while empty.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties the FIFO)
//   push, push_dat    write one rf_wr_t entry
//   pop               retire the head entry
//   head              current oldest entry (valid when empty=0)
//   full, empty       occupancy flags
//   count             number of stored entries (0..LD_DEPTH)
import rf_pkg::*;

module rf_ld_fifo #(
  parameter int LD_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  rf_wr_t                      push_dat,
  input  logic                        pop,
  output rf_wr_t                      head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(LD_DEPTH):0]   count
);

  localparam int PW    = $clog2(LD_DEPTH);
  localparam int CNT_W = PW + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LD_DEPTH);

  rf_wr_t          mem [LD_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset: contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU writeback and returned loads; tracks outstanding loads.
// Latency: grant at edge N drives rf_we/rf_waddr/rf_wdata during cycle N+1; a load through an empty FIFO writes at push+2.
// Backpressure: alu_ready drops on WAW (dest has a pending load) or FIFO full; ld_ready = !full; issue_ready = !busy[issue_rd].
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data       ALU writeback request; alu_ready = granted this cycle
//   ld_valid/ld_rd/ld_data          returned load; ld_ready = accepted into FIFO this cycle
//   issue_valid/issue_rd            load issued to memory; issue_ready = destination not already pending
//   rs1, rs2 -> hazard              decode sources; hazard = decode must stall
//   rf_we/rf_waddr/rf_wdata         registered register-file write port
//   byp1_hit/byp2_hit/byp_data      forwarding of the in-flight write (only with RF_WRITE_BYPASS_EN)
//
// Build option RF_WRITE_BYPASS_EN: adds the bypass outputs and drops the in-flight
// write from hazard, since decode can forward it instead of stalling.
import rf_pkg::*;

module rf_write_arbiter #(
  parameter int LD_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  ld_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hazard,
`ifdef RF_WRITE_BYPASS_EN
  output logic                  byp1_hit,
  output logic                  byp2_hit,
  output logic [XLEN-1:0]       byp_data,
`endif
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int CNT_W = $clog2(LD_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LD_DEPTH);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  rf_wr_t              ld_head;
  rf_wr_t              wr_sel;
  logic                ld_full;
  logic                ld_empty;
  logic [CNT_W-1:0]    ld_count;
  logic                ld_push;
  logic                ld_pop;
  logic                alu_block;
  logic                alu_grant;
  logic                wr_vld;

  rf_ld_fifo #(
    .LD_DEPTH (LD_DEPTH)
  ) u_ld_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (ld_push),
    .push_dat ('{rd: ld_rd, data: ld_data}),
    .pop      (ld_pop),
    .head     (ld_head),
    .full     (ld_full),
    .empty    (ld_empty),
    .count    (ld_count)
  );

  assign ld_ready    = !ld_full;
  assign ld_push     = ld_valid && !ld_full;
  assign issue_ready = !busy[issue_rd];

  // ALU wins unless it would overtake a pending load to the same register
  // (WAW) or the FIFO is full; a full FIFO forces a drain so loads never starve.
  always_comb begin
    alu_block = alu_valid && busy[alu_rd];
    alu_grant = alu_valid && !alu_block && !ld_full;
    ld_pop    = !alu_grant && !ld_empty;
    wr_vld    = alu_grant || ld_pop;
    wr_sel    = alu_grant ? '{rd: alu_rd, data: alu_data} : ld_head;
  end

  assign alu_ready = alu_grant;

  // Scoreboard update: clear on pop first so a same-cycle issue to that rd wins.
  always_comb begin
    busy_nxt = busy;
    if (ld_pop) begin
      busy_nxt[ld_head.rd] = 1'b0;
    end
    if (issue_valid && issue_ready && (issue_rd != '0)) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      busy  <= busy_nxt;
      // Writes to x0 are consumed by the grant but never reach the register file.
      rf_we <= wr_vld && (wr_sel.rd != '0);
      if (wr_vld) begin
        rf_waddr <= wr_sel.rd;
        rf_wdata <= wr_sel.data;
      end
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  assign byp1_hit = rf_we && (rf_waddr == rs1) && (rs1 != '0);
  assign byp2_hit = rf_we && (rf_waddr == rs2) && (rs2 != '0);
  assign byp_data = rf_wdata;
  assign hazard   = busy[rs1] | busy[rs2];
`else
  // Without forwarding, a write still sitting in the output register has not
  // yet been committed to the register file, so decode must wait one more cycle.
  assign hazard = busy[rs1] | busy[rs2]
                | (rf_we && (((rf_waddr == rs1) && (rs1 != '0))
                          || ((rf_waddr == rs2) && (rs2 != '0))));
`endif

  assert property (@(posedge clk) disable iff (reset) ld_count <= DEPTH_C);

endmodule
